bnn_conv_mc: RTL and testbench
==============================

Name: bnn_conv_mc

Overview:
- Multi-channel binary 3x3 convolution engine; next generation of the team's single-kernel XNOR/popcount SRAM accelerator.
- Reads a sequence of bit-packed square images from the input SRAM and up to MAX_CH 9-bit kernels from the weight SRAM.
- Writes one thresholded output row per (image, kernel, row position) back to the output SRAM.
- Generalised in row width, kernel count and threshold. Image size N is any value 3..DATA_W, not a fixed set.

Parameters:
- DATA_W, 16: SRAM word width; maximum image dimension N.
- ADDR_W, 12: SRAM address width.
- MAX_CH, 4: maximum number of kernels held on chip.
- THRESH, 5: output bit is 1 when XNOR popcount >= THRESH (range 0..9).

Ports:
- clk  in  1  single clock, rising edge.
- reset_b  in  1  asynchronous, active-low reset.
- dut_run  in  1  start pulse; sampled only in IDLE.
- dut_busy  out  1  high from the cycle after an accepted dut_run until the last write completes.
- dut_sram_read_address  out  ADDR_W  input SRAM read address.
- sram_dut_read_data  in  DATA_W  input SRAM data, valid 1 cycle after the address.
- dut_sram_write_address  out  ADDR_W  output SRAM write address.
- dut_sram_write_data  out  DATA_W  output SRAM write data.
- dut_sram_write_enable  out  1  write strobe.
- dut_wmem_read_address  out  ADDR_W  weight SRAM read address.
- wmem_dut_read_data  in  DATA_W  weight SRAM data, 1-cycle latency.

Behaviour:
- Reset: all outputs 0. Kernel registers, counters and pointers are cleared.
- Reset mid-run aborts immediately; no further writes.
- Weight memory layout: word 0 holds K in [3:0]; words 1..K hold the kernels in bits [8:0]. Bit 3*r+c is kernel row r, column c.
- K=0 is treated as 1. K>MAX_CH is clamped to MAX_CH.
- Input memory layout, per image:
  - One header word holding N in [4:0].
  - Then N row words; bit j of a row is column j.
  - The next header follows immediately after the last row.
  - A header equal to 16'h00FF terminates the run.
- FSM:
  - IDLE: on dut_run go to WLOAD.
  - WLOAD: read weight words 0..K into the kernel regfile (K+2 cycles), then go to HDR.
  - HDR: read the header. 00FF goes to DONE; otherwise latch N, set ch=0 and go to FILL.
  - FILL: read rows 0..2 into a 3-row shift window, then go to CONV.
  - CONV: each cycle shift in the next row and write one output row. N-2 writes per channel.
  - Channel end: if ch<K-1, ch++ and go back to FILL; the image rows are re-read from the same row base. Otherwise advance the input pointer by N+1 and go to HDR.
  - DONE: deassert dut_busy the next cycle and return to IDLE.
- Output bit j (0..N-3) = (popcount(XNOR(kernel[ch], window columns j..j+2 of rows r..r+2)) >= THRESH).
- Bits N-2..DATA_W-1 of each output word are 0.
- Write address starts at 0 on each run and increments by 1 per write across all images and channels. The output order is image-major, then channel, then row.
- dut_sram_write_enable is registered and high only on valid output words; there are no gaps inside one channel's N-2 rows.
- Address arithmetic is ADDR_W-bit and wraps modulo 2^ADDR_W without error.
- dut_run while busy is ignored.
- An empty sequence (first header 00FF) produces zero writes; dut_busy is high for WLOAD+HDR+DONE only.

Optional Feature:
- Macro: BNN_DIM_CHECK_EN.
- When defined:
  - Adds output port dut_error (1 bit, reset 0).
  - A non-terminator header with N<3 or N>DATA_W ends the run as in DONE and sets dut_error.
  - dut_error stays set until the next accepted dut_run.
- When undefined: there is no dut_error port, and N is used modulo 32 unchecked. Behaviour for out-of-range N is unspecified.

Decomposition:
- Package bnn_conv_pkg holds:
  - the FSM state enum;
  - the terminator constant 16'h00FF;
  - header/weight field widths;
  - a popcount9 function.
- Sub-module bnn_pe: combinational 9-bit XNOR, popcount and compare against THRESH. It is instantiated DATA_W-2 times in a generate loop.

Test Plan:
- Single 10x10 image of all ones, K=1, kernel 9'h1FF, THRESH=5 -> 8 writes at addresses 0..7, each 16'h00FF; dut_busy then falls.
- Single 16x16 checkerboard, K=2, kernels 9'h155 and 9'h0AA -> 28 writes. Channel 0 rows alternate 16'h1555 and 16'h2AAA; channel 1 rows are their complements masked to 14 bits.
- Two images (N=12, then N=3), K=3 -> 3*10 + 3*1 = 33 writes. The last word is bit 0 only; header pointer checks are 0 and 13.
- THRESH=9, random image, N=16 -> output bit set only on exact kernel match; compare against the reference model bit for bit.
- First header 16'h00FF -> no write strobes; dut_busy high for K+4 cycles. dut_run pulsed mid-run -> ignored. reset_b low mid-CONV -> outputs 0 within the same cycle.
- With BNN_DIM_CHECK_EN, header N=2 -> zero writes and dut_error=1. The next dut_run clears dut_error.

Source files
------------

// File: rtl/bnn_conv_pkg.sv
// ============================================================================
//  Module      : bnn_conv_pkg
//  Description : Shared types, header/weight field widths and popcount helper
//                for the multi-channel binary 3x3 convolution engine.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bnn_conv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WLOAD = 3'd1,
        ST_HDR   = 3'd2,
        ST_FILL  = 3'd3,
        ST_CONV  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    localparam logic [15:0] c_hdr_term = 16'h00FF;
    localparam int          c_hdr_n_w  = 5;
    localparam int          c_wgt_k_w  = 4;
    localparam int          c_kern_w   = 9;

    function automatic logic [3:0] popcount9(input logic [8:0] v);
        logic [3:0] s;
        s = 4'd0;
        for (int i = 0; i < 9; i++) begin
            s = s + {3'b000, v[i]};
        end
        return s;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bnn_pe.sv
// ============================================================================
//  Module      : bnn_pe
//  Description : One output pixel: 9-bit XNOR against the kernel, popcount,
//                compare against THRESH.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bnn_pe
    import bnn_conv_pkg::*;
#(
    parameter int THRESH = 5
) (
    input  logic [c_kern_w-1:0] i_kernel,
    input  logic [c_kern_w-1:0] i_window,
    output logic                o_bit
);

    localparam logic [4:0] c_thresh = 5'(THRESH);

    logic [3:0] w_count;

    always_comb begin
        w_count = popcount9(~(i_kernel ^ i_window));
        o_bit   = ({1'b0, w_count} >= c_thresh);
    end

endmodule

`default_nettype wire

// File: rtl/bnn_conv_mc.sv
// ============================================================================
//  Module      : bnn_conv_mc
//  Description : Multi-channel binary 3x3 XNOR/popcount convolution over a
//                sequence of SRAM images. Optional BNN_DIM_CHECK_EN adds
//                dut_error and rejects headers with N outside 3..DATA_W.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bnn_conv_mc
    import bnn_conv_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 12,
    parameter int MAX_CH = 4,
    parameter int THRESH = 5
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic              dut_run,
    output logic              dut_busy,
    output logic [ADDR_W-1:0] dut_sram_read_address,
    input  logic [DATA_W-1:0] sram_dut_read_data,
    output logic [ADDR_W-1:0] dut_sram_write_address,
    output logic [DATA_W-1:0] dut_sram_write_data,
    output logic              dut_sram_write_enable,
    output logic [ADDR_W-1:0] dut_wmem_read_address,
    input  logic [DATA_W-1:0] wmem_dut_read_data
`ifdef BNN_DIM_CHECK_EN
    ,
    output logic              dut_error
`endif
);

    localparam logic [ADDR_W-1:0] c_addr_one = ADDR_W'(1);

    state_t                 state_q, state_d;
    logic [c_hdr_n_w-1:0]   cnt_q, cnt_d;
    logic [c_wgt_k_w-1:0]   k_q, k_d;
    logic [c_wgt_k_w-1:0]   ch_q, ch_d;
    logic [c_hdr_n_w-1:0]   n_q, n_d;
    logic [ADDR_W-1:0]      ptr_q, ptr_d;
    logic [ADDR_W-1:0]      rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0]      wm_addr_q, wm_addr_d;
    logic [ADDR_W-1:0]      wr_cnt_q, wr_cnt_d;
    logic [ADDR_W-1:0]      wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]      wr_data_q, wr_data_d;
    logic                   wr_en_q, wr_en_d;
    logic                   busy_q, busy_d;
    logic [DATA_W-1:0]      row0_q, row0_d;
    logic [DATA_W-1:0]      row1_q, row1_d;
    logic [DATA_W-1:0]      row2_q, row2_d;
    logic [c_kern_w-1:0]    kern_q [MAX_CH];
    logic [c_kern_w-1:0]    kern_d [MAX_CH];
`ifdef BNN_DIM_CHECK_EN
    logic                   err_q, err_d;
    logic                   w_n_bad;
`endif

    logic [c_wgt_k_w-1:0]   w_k_clamped;
    logic [c_kern_w-1:0]    w_kern_sel;
    logic [DATA_W-3:0]      w_pe_bits;
    logic [DATA_W-3:0]      w_mask;
    logic [DATA_W-1:0]      w_row_out;
    logic                   w_hdr_term;
    logic                   w_unused;

    assign w_unused = ^wmem_dut_read_data[DATA_W-1:c_kern_w];

    always_comb begin
        w_k_clamped = wmem_dut_read_data[c_wgt_k_w-1:0];
        if (w_k_clamped == 4'd0) begin
            w_k_clamped = 4'd1;
        end else if (w_k_clamped > 4'(MAX_CH)) begin
            w_k_clamped = 4'(MAX_CH);
        end
        w_kern_sel = '0;
        for (int i = 0; i < MAX_CH; i++) begin
            if (ch_q == 4'(i)) begin
                w_kern_sel = kern_q[i];
            end
        end
        w_hdr_term = (sram_dut_read_data == DATA_W'(c_hdr_term));
`ifdef BNN_DIM_CHECK_EN
        w_n_bad = (sram_dut_read_data[c_hdr_n_w-1:0] < 5'd3) ||
                  ({1'b0, sram_dut_read_data[c_hdr_n_w-1:0]} > 6'(DATA_W));
`endif
    end

    // Window bit 3*r+c is image row (out_row+r), column (j+c).
    for (genvar j = 0; j < DATA_W - 2; j++) begin : g_pe
        bnn_pe #(
            .THRESH (THRESH)
        ) u_pe (
            .i_kernel (w_kern_sel),
            .i_window ({row2_q[j+2], row2_q[j+1], row2_q[j],
                        row1_q[j+2], row1_q[j+1], row1_q[j],
                        row0_q[j+2], row0_q[j+1], row0_q[j]}),
            .o_bit    (w_pe_bits[j])
        );
        assign w_mask[j] = ({1'b0, n_q} > 6'(j + 2));
    end

    assign w_row_out = {2'b00, w_pe_bits & w_mask};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        k_d       = k_q;
        ch_d      = ch_q;
        n_d       = n_q;
        ptr_d     = ptr_q;
        rd_addr_d = rd_addr_q;
        wm_addr_d = wm_addr_q;
        wr_cnt_d  = wr_cnt_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wr_en_d   = 1'b0;
        row0_d    = row0_q;
        row1_d    = row1_q;
        row2_d    = row2_q;
        kern_d    = kern_q;
`ifdef BNN_DIM_CHECK_EN
        err_d     = err_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (dut_run) begin
                    state_d   = ST_WLOAD;
                    cnt_d     = '0;
                    ptr_d     = '0;
                    rd_addr_d = '0;
                    wm_addr_d = '0;
                    wr_cnt_d  = '0;
`ifdef BNN_DIM_CHECK_EN
                    err_d     = 1'b0;
`endif
                end
            end
            // Weight addresses are issued every cycle; data trails by one,
            // and the first header address (ptr) is already on the input bus.
            ST_WLOAD: begin
                wm_addr_d = wm_addr_q + c_addr_one;
                cnt_d     = cnt_q + 5'd1;
                if (cnt_q == 5'd1) begin
                    k_d = w_k_clamped;
                end else if (cnt_q >= 5'd2) begin
                    for (int i = 0; i < MAX_CH; i++) begin
                        if (cnt_q - 5'd2 == 5'(i)) begin
                            kern_d[i] = wmem_dut_read_data[c_kern_w-1:0];
                        end
                    end
                    if (cnt_q - 5'd1 == {1'b0, k_q}) begin
                        state_d = ST_HDR;
                        cnt_d   = 5'd1;
                    end
                end
            end
            // cnt 0 means the header address is being issued this cycle.
            ST_HDR: begin
                if (cnt_q == 5'd0) begin
                    cnt_d = 5'd1;
                end else if (w_hdr_term) begin
                    state_d = ST_DONE;
`ifdef BNN_DIM_CHECK_EN
                end else if (w_n_bad) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
`endif
                end else begin
                    n_d       = sram_dut_read_data[c_hdr_n_w-1:0];
                    ch_d      = '0;
                    cnt_d     = '0;
                    rd_addr_d = ptr_q + c_addr_one;
                    state_d   = ST_FILL;
                end
            end
            ST_FILL: begin
                rd_addr_d = rd_addr_q + c_addr_one;
                cnt_d     = cnt_q + 5'd1;
                if (cnt_q != 5'd0) begin
                    row0_d = row1_q;
                    row1_d = row2_q;
                    row2_d = sram_dut_read_data;
                end
                if (cnt_q == 5'd3) begin
                    state_d = ST_CONV;
                    cnt_d   = '0;
                end
            end
            ST_CONV: begin
                rd_addr_d = rd_addr_q + c_addr_one;
                cnt_d     = cnt_q + 5'd1;
                row0_d    = row1_q;
                row1_d    = row2_q;
                row2_d    = sram_dut_read_data;
                wr_en_d   = 1'b1;
                wr_data_d = w_row_out;
                wr_addr_d = wr_cnt_q;
                wr_cnt_d  = wr_cnt_q + c_addr_one;
                if (cnt_q == n_q - 5'd3) begin
                    cnt_d = '0;
                    if (ch_q < k_q - 4'd1) begin
                        ch_d      = ch_q + 4'd1;
                        rd_addr_d = ptr_q + c_addr_one;
                        state_d   = ST_FILL;
                    end else begin
                        ptr_d     = ptr_q + {{(ADDR_W-c_hdr_n_w){1'b0}}, n_q} + c_addr_one;
                        rd_addr_d = ptr_q + {{(ADDR_W-c_hdr_n_w){1'b0}}, n_q} + c_addr_one;
                        state_d   = ST_HDR;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            k_q       <= '0;
            ch_q      <= '0;
            n_q       <= '0;
            ptr_q     <= '0;
            rd_addr_q <= '0;
            wm_addr_q <= '0;
            wr_cnt_q  <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            row0_q    <= '0;
            row1_q    <= '0;
            row2_q    <= '0;
            for (int i = 0; i < MAX_CH; i++) begin
                kern_q[i] <= '0;
            end
`ifdef BNN_DIM_CHECK_EN
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            k_q       <= k_d;
            ch_q      <= ch_d;
            n_q       <= n_d;
            ptr_q     <= ptr_d;
            rd_addr_q <= rd_addr_d;
            wm_addr_q <= wm_addr_d;
            wr_cnt_q  <= wr_cnt_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            wr_en_q   <= wr_en_d;
            busy_q    <= busy_d;
            row0_q    <= row0_d;
            row1_q    <= row1_d;
            row2_q    <= row2_d;
            for (int i = 0; i < MAX_CH; i++) begin
                kern_q[i] <= kern_d[i];
            end
`ifdef BNN_DIM_CHECK_EN
            err_q     <= err_d;
`endif
        end
    end

    assign dut_busy               = busy_q;
    assign dut_sram_read_address  = rd_addr_q;
    assign dut_sram_write_address = wr_addr_q;
    assign dut_sram_write_data    = wr_data_q;
    assign dut_sram_write_enable  = wr_en_q;
    assign dut_wmem_read_address  = wm_addr_q;
`ifdef BNN_DIM_CHECK_EN
    assign dut_error              = err_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bnn_conv_mc.sv
// ============================================================================
//  Module      : tb_bnn_conv_mc
//  Description : Directed bench for bnn_conv_mc with a behavioural
//                convolution model and a per-write scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bnn_conv_mc;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 12;
    localparam int MAX_CH = 4;
    localparam int THRESH = 5;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } wr_t;

    logic              clk = 1'b0;
    logic              reset_b = 1'b0;
    logic              dut_run = 1'b0;
    logic              dut_busy;
    logic [ADDR_W-1:0] dut_sram_read_address;
    logic [DATA_W-1:0] sram_dut_read_data = '0;
    logic [ADDR_W-1:0] dut_sram_write_address;
    logic [DATA_W-1:0] dut_sram_write_data;
    logic              dut_sram_write_enable;
    logic [ADDR_W-1:0] dut_wmem_read_address;
    logic [DATA_W-1:0] wmem_dut_read_data = '0;
`ifdef BNN_DIM_CHECK_EN
    logic              dut_error;
`endif

    logic [DATA_W-1:0] imem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] wmem [0:(1<<ADDR_W)-1];
    wr_t               exp_q [$];
    int                n_vec = 0;
    int                n_bad = 0;
    int                n_writes = 0;
    int                busy_cyc = 0;

    bnn_conv_mc #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .MAX_CH (MAX_CH),
        .THRESH (THRESH)
    ) u_dut (
        .clk                    (clk),
        .reset_b                (reset_b),
        .dut_run                (dut_run),
        .dut_busy               (dut_busy),
        .dut_sram_read_address  (dut_sram_read_address),
        .sram_dut_read_data     (sram_dut_read_data),
        .dut_sram_write_address (dut_sram_write_address),
        .dut_sram_write_data    (dut_sram_write_data),
        .dut_sram_write_enable  (dut_sram_write_enable),
        .dut_wmem_read_address  (dut_wmem_read_address),
        .wmem_dut_read_data     (wmem_dut_read_data)
`ifdef BNN_DIM_CHECK_EN
        ,
        .dut_error              (dut_error)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        sram_dut_read_data <= imem[dut_sram_read_address];
        wmem_dut_read_data <= wmem[dut_wmem_read_address];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (reset_b && dut_sram_write_enable) begin
            wr_t e;
            n_writes++;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL extra_write: got addr %h data %h, required no write",
                         dut_sram_write_address, dut_sram_write_data);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(dut_sram_write_address), 32'(e.a));
                check("wr_data", 32'(dut_sram_write_data), 32'(e.d));
            end
        end
    end

    // Straight from the memory layout: images, channels, rows, columns.
    task automatic build_model();
        int k, p, n, addr, cnt, nimg;
        logic [8:0]        kern [MAX_CH];
        logic [DATA_W-1:0] word, hdr, row;
        exp_q.delete();
        k = int'(wmem[0][3:0]);
        if (k == 0) k = 1;
        if (k > MAX_CH) k = MAX_CH;
        for (int i = 0; i < k; i++) kern[i] = wmem[1+i][8:0];
        p = 0; addr = 0; nimg = 0;
        while (nimg < 64) begin
            hdr = imem[p % 4096];
            if (hdr == 16'h00FF) break;
            n = int'(hdr[4:0]);
            for (int ch = 0; ch < k; ch++) begin
                for (int r = 0; r <= n - 3; r++) begin
                    word = '0;
                    for (int j = 0; j <= n - 3; j++) begin
                        cnt = 0;
                        for (int rr = 0; rr < 3; rr++) begin
                            row = imem[(p + 1 + r + rr) % 4096];
                            for (int cc = 0; cc < 3; cc++) begin
                                if (row[j+cc] == kern[ch][3*rr+cc]) cnt++;
                            end
                        end
                        word[j] = (cnt >= THRESH);
                    end
                    exp_q.push_back('{a: ADDR_W'(addr), d: word});
                    addr++;
                end
            end
            p = p + n + 1;
            nimg++;
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 4096; i++) begin
            imem[i] = '0;
            wmem[i] = '0;
        end
    endtask

    task automatic do_run(input string name, input bit poke);
        int t;
        n_writes = 0;
        busy_cyc = 0;
        @(negedge clk); dut_run = 1'b1;
        @(negedge clk); dut_run = 1'b0;
        t = 0;
        while (dut_busy && t < 20000) begin
            busy_cyc++;
            if (poke && t == 30) dut_run = 1'b1;
            if (poke && t == 31) dut_run = 1'b0;
            @(negedge clk);
            t++;
        end
        dut_run = 1'b0;
        if (t >= 20000) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s_timeout: got busy after %0d cycles, required idle", name, t);
        end
        check({name, "_drain"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_busy_we"}, {30'd0, dut_busy, dut_sram_write_enable}, 32'd0);
        check({name, "_rd_wr_addr"}, 32'({dut_sram_read_address, dut_sram_write_address}), 32'd0);
        check({name, "_wdata_wmaddr"}, 32'({dut_sram_write_data, dut_wmem_read_address}), 32'd0);
    endtask

    initial begin
        int t;
        clear_mem();
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        reset_b = 1'b1;
        repeat (2) @(negedge clk);

        // 10x10 all ones, K=1, kernel all ones
        clear_mem();
        wmem[0] = 16'd1; wmem[1] = 16'h01FF;
        imem[0] = 16'd10;
        for (int i = 1; i <= 10; i++) imem[i] = 16'h03FF;
        imem[11] = 16'h00FF;
        build_model();
        check("model_ones_count", 32'(exp_q.size()), 32'd8);
        check("model_ones_word", 32'(exp_q[7].d), 32'h00FF);
        do_run("ones", 1'b0);
        check("ones_writes", 32'(n_writes), 32'd8);
        check("ones_busy_fell", {31'd0, dut_busy}, 32'd0);

        // 16x16 checkerboard, K=2, with a dut_run pulse while busy
        clear_mem();
        wmem[0] = 16'd2; wmem[1] = 16'h0155; wmem[2] = 16'h00AA;
        imem[0] = 16'd16;
        for (int i = 0; i < 16; i++) imem[1+i] = (i % 2 == 0) ? 16'h5555 : 16'hAAAA;
        imem[17] = 16'h00FF;
        build_model();
        check("model_chk_count", 32'(exp_q.size()), 32'd28);
        check("model_chk_c0r0", 32'(exp_q[0].d), 32'h1555);
        check("model_chk_c0r1", 32'(exp_q[1].d), 32'h2AAA);
        check("model_chk_c1r0", 32'(exp_q[14].d), 32'h2AAA);
        do_run("checker", 1'b1);
        check("checker_writes", 32'(n_writes), 32'd28);

        // N=12 random then N=3 ones, K=3
        clear_mem();
        wmem[0] = 16'd3; wmem[1] = 16'h01FF; wmem[2] = 16'h00F0; wmem[3] = 16'h01FF;
        imem[0] = 16'd12;
        for (int i = 1; i <= 12; i++) imem[i] = 16'($urandom) & 16'h0FFF;
        imem[13] = 16'd3;
        for (int i = 14; i <= 16; i++) imem[i] = 16'h0007;
        imem[17] = 16'h00FF;
        build_model();
        check("model_two_count", 32'(exp_q.size()), 32'd33);
        check("model_two_last", 32'(exp_q[32].d), 32'h0001);
        do_run("two_img", 1'b0);
        check("two_img_writes", 32'(n_writes), 32'd33);

        // K=7 clamps to MAX_CH, random N=16 image
        clear_mem();
        wmem[0] = 16'd7;
        for (int i = 1; i <= 7; i++) wmem[i] = 16'($urandom) & 16'h01FF;
        imem[0] = 16'd16;
        for (int i = 1; i <= 16; i++) imem[i] = 16'($urandom);
        imem[17] = 16'h00FF;
        build_model();
        check("model_clamp_count", 32'(exp_q.size()), 32'd56);
        do_run("clamp", 1'b0);

        // K=0 is one kernel; N=5 zeros against a zero kernel
        clear_mem();
        wmem[0] = 16'd0; wmem[1] = 16'h0000;
        imem[0] = 16'd5;
        imem[6] = 16'h00FF;
        build_model();
        check("model_k0_count", 32'(exp_q.size()), 32'd3);
        check("model_k0_word", 32'(exp_q[0].d), 32'h0007);
        do_run("k0", 1'b0);

        // Empty sequence: busy for K+4 cycles, no writes
        clear_mem();
        wmem[0] = 16'd2; wmem[1] = 16'h0011; wmem[2] = 16'h0022;
        imem[0] = 16'h00FF;
        build_model();
        do_run("empty", 1'b0);
        check("empty_busy_cycles", 32'(busy_cyc), 32'd6);
        check("empty_writes", 32'(n_writes), 32'd0);

        // Reset mid-CONV
        clear_mem();
        wmem[0] = 16'd1; wmem[1] = 16'h01FF;
        imem[0] = 16'd16;
        for (int i = 1; i <= 16; i++) imem[i] = 16'($urandom);
        imem[17] = 16'h00FF;
        build_model();
        n_writes = 0;
        @(negedge clk); dut_run = 1'b1;
        @(negedge clk); dut_run = 1'b0;
        t = 0;
        while (!dut_sram_write_enable && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("rst_reach_conv", {31'd0, dut_sram_write_enable}, 32'd1);
        @(posedge clk); #2;
        reset_b = 1'b0;
        #1;
        check_outputs_zero("midrst");
        exp_q.delete();
        repeat (3) @(negedge clk);
        reset_b = 1'b1;
        n_writes = 0;
        repeat (40) @(negedge clk);
        check("midrst_no_writes", 32'(n_writes), 32'd0);
        check("midrst_idle", {31'd0, dut_busy}, 32'd0);

`ifdef BNN_DIM_CHECK_EN
        clear_mem();
        wmem[0] = 16'd1; wmem[1] = 16'h01FF;
        imem[0] = 16'd2;
        exp_q.delete();
        do_run("dimchk", 1'b0);
        check("dimchk_writes", 32'(n_writes), 32'd0);
        check("dimchk_error", {31'd0, dut_error}, 32'd1);
        imem[0] = 16'h00FF;
        do_run("dimclr", 1'b0);
        check("dimclr_error", {31'd0, dut_error}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
